// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem addressing, redirects, stalls, halt detection.
// Optional single-step debug gating is compiled in with `define FETCH_STEP_EN.
module fetch_unit #(
    parameter int unsigned  B         = 32,
    parameter int unsigned  ADDR_W    = 7,
    parameter logic [B-1:0] HALT_WORD = B'(32'hFFFF_FFFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disa,
    input  logic              branch_taken,
    input  logic [B-1:0]      branch_target,
    input  logic              jump,
    input  logic [B-1:0]      jump_target,
    input  logic              step_mode,
    input  logic              step_pulse,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [B-1:0]      imem_data,
    output logic [B-1:0]      pc_incrementado_out,
    output logic [B-1:0]      instruction_out,
    output logic [B-1:0]      pc_out,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam int unsigned CNT_W = 32;

`ifdef FETCH_STEP_EN
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT      = 2'd1,
        ST_STEP_IDLE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1
    } state_e;

    logic step_unused;
    assign step_unused = step_mode | step_pulse;
`endif

    state_e             state_q, state_d;
    logic [B-1:0]       pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               redirect;
    logic               issue;
    logic               send;
    logic [B-1:0]       target;

    // State, PC and issue counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Next-state, next-PC and the gated instruction presented to IF/ID
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        count_d         = count_q;
        instruction_out = '0;

        redirect = (jump | branch_taken) && (state_q != ST_HALT);
        target   = jump ? jump_target : branch_target;
`ifdef FETCH_STEP_EN
        issue = !redirect && !disa && (state_q != ST_HALT)
                && ((state_q == ST_RUN) || step_pulse);
`else
        issue = !redirect && !disa && (state_q != ST_HALT);
`endif
        // A fetched halt word is swallowed: PC holds and the FSM parks in HALT
        send = issue && (imem_data != HALT_WORD);

        if (redirect) begin
            pc_d = target;
        end else if (send) begin
            pc_d = pc_q + B'(4);
        end

        if (send) begin
            count_d         = count_q + CNT_W'(1);
            instruction_out = imem_data;
        end

        case (state_q)
            ST_RUN: begin
                if (issue && !send) begin
                    state_d = ST_HALT;
                end
`ifdef FETCH_STEP_EN
                else if (step_mode) begin
                    state_d = ST_STEP_IDLE;
                end
            end
            ST_STEP_IDLE: begin
                if (issue && !send) begin
                    state_d = ST_HALT;
                end else if (!step_mode) begin
                    state_d = ST_RUN;
                end
`endif
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    assign imem_addr           = pc_q[ADDR_W+1:2];
    assign pc_out              = pc_q;
    assign pc_incrementado_out = pc_q + B'(4);
    assign halted              = (state_q == ST_HALT);
    assign fetch_count         = count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter, addresses the instruction memory, applies branch/jump redirects, stalls and halt detection, and presents `pc_incrementado_out`/`instruction_out` to the IF/ID latch every cycle. Sits directly upstream of `latch_IF_ID`; its outputs connect to that latch's `pc_incrementado_in`/`instruction_in`, and its `disa` input is shared with the latch.

## Interface
- `B`, 32, data/PC width
- `ADDR_W`, 7, instruction-memory word-address width
- `HALT_WORD`, 32'hFFFFFFFF, encoding that stops fetch

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears PC, FSM, counter
- `disa`  in  1  load-use stall from hazard unit; hold PC
- `branch_taken`  in  1  redirect to `branch_target`
- `branch_target`  in  B  byte address
- `jump`  in  1  redirect to `jump_target`
- `jump_target`  in  B  byte address
- `step_mode`  in  1  debug single-step enable
- `step_pulse`  in  1  one-cycle pulse: issue one instruction in step mode
- `imem_addr`  out  ADDR_W  word address = `pc[ADDR_W+1:2]`
- `imem_data`  in  B  instruction, combinational read of `imem_addr`
- `pc_incrementado_out`  out  B  `pc + 4`
- `instruction_out`  out  B  instruction to IF/ID, or 0 (NOP bubble)
- `pc_out`  out  B  current PC
- `halted`  out  1  FSM in HALT
- `fetch_count`  out  32  instructions issued since reset

## Operation
- FSM states: RUN, STEP_IDLE, HALT. Reset state RUN.
- `redirect = (jump | branch_taken) & state != HALT`; target = `jump_target` if `jump`, else `branch_target`.
- `issue = !redirect & !disa & state != HALT & (state == RUN | step_pulse)`.
- `instruction_out = imem_data` only when `issue` and `imem_data != HALT_WORD`; otherwise 0.
- PC next-value priority: reset > redirect (PC <= target) > halt-word issue (PC holds) > `issue` (PC <= pc+4) > hold.
- Redirect beats `disa` and step gating; wrong-path word is replaced by 0. Jump beats branch.
- Halt: `issue & imem_data == HALT_WORD` -> state HALT next edge; halt word never sent downstream; not counted.
- HALT exits only on `reset`; all redirects, stalls and step pulses ignored; output permanently 0, pipeline drains.
- RUN -> STEP_IDLE at an edge with `step_mode=1`; STEP_IDLE -> RUN at an edge with `step_mode=0`. In STEP_IDLE each `step_pulse` cycle issues exactly one instruction.
- `fetch_count` += 1 on each edge where `issue & imem_data != HALT_WORD`; wraps 2^32-1 -> 0.
- PC arithmetic modulo 2^B; `pc_incrementado_out` wraps likewise. Targets used as given, low 2 bits not masked.

## Timing
- Reset values: PC=0, `pc_out`=0, `pc_incrementado_out`=4, `imem_addr`=0, `halted`=0, `fetch_count`=0, state RUN; `instruction_out` = `imem_data[0]` (combinational, gated as above).
- PC, state, counter update on rising `clk`; all outputs combinational from registers and `imem_data`, zero added latency. IF/ID captures them the same edge.
- Redirect asserted in cycle n: bubble in cycle n, target instruction presented in cycle n+1.
- `disa` high for k cycles: same PC and outputs held k cycles, `instruction_out` = 0 (latch also holds).
- Reset asserted mid-operation clears everything immediately, independent of `clk`.

## Configuration
- `FETCH_STEP_EN` defined: STEP_IDLE state and `step_mode`/`step_pulse` behave as above.
- Not defined: ports remain but are ignored; FSM is RUN/HALT only; `issue` omits the step term.

## Test plan
- Reset, `imem` = sequential words 0x20080001.. -> PC 0,4,8,12 on successive edges; `instruction_out` follows mem; `fetch_count`=4 after 4 edges.
- `disa`=1 for 2 cycles at PC=8 -> PC stays 8, `instruction_out`=0 both cycles, resumes at 8, count unchanged.
- `branch_taken`=1, target 0x40, with `disa`=1 same cycle -> bubble, PC=0x40 next; with `jump`=1 target 0x80 too -> PC=0x80.
- Word 0xFFFFFFFF at PC=0x10 -> `instruction_out`=0, `halted`=1 next edge, PC stuck 0x10, later `jump` ignored; reset clears.
- `FETCH_STEP_EN`: `step_mode`=1, three `step_pulse` spaced 4 cycles -> PC advances exactly 3 words, bubbles between; undefined macro -> continuous fetch.
- `fetch_count` preloaded near wrap via 2^32 issues (or forced) -> 0xFFFFFFFF -> 0.
